// File: rtl/tick_sched.sv
// tick_sched: run/pause/idle tick scheduler with a programmable period,
// a BCD tick digit with carry, and a free-running display scan counter.
module tick_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  input  logic        div_load,
  input  logic [26:0] div_val,
  output logic        tick,
  output logic [3:0]  digit,
  output logic        carry,
  output logic [1:0]  scan_sel,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  // 1 Hz at 50 MHz
  localparam logic [26:0] PER_RST = 27'd49_999_999;

  state_t      cur, nxt;
  logic [26:0] cnt;
  logic [26:0] per_reg;
  logic [18:0] scan_cnt;
  logic        counting;
  logic        at_end;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= IDLE;
    else       cur <= nxt;
  end

  // Next state: the highest-priority asserted command is selected first and
  // then applied, so a pause that is a no-op still masks a same-cycle start.
  always_comb begin
    nxt = cur;
    if (clear) begin
      nxt = IDLE;
    end else if (pause) begin
      if (cur == RUN) nxt = PAUSE;
    end else if (start) begin
      if (cur != RUN) nxt = RUN;
    end
    if (cur != IDLE && cur != RUN && cur != PAUSE) nxt = IDLE;
  end

  // Counting only on edges that stay in RUN; entering RUN from IDLE/PAUSE
  // does not count, which puts the first tick per_reg+1 edges after start.
  assign counting = (cur == RUN) && (nxt == RUN);
  assign at_end   = counting && (cnt == per_reg);

  // Period counter, tick, digit and carry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      digit <= '0;
      tick  <= 1'b0;
      carry <= 1'b0;
    end else begin
      tick  <= 1'b0;
      carry <= 1'b0;
      if (clear) begin
        cnt   <= '0;
        digit <= '0;
      end else if (at_end) begin
        cnt  <= '0;
        tick <= 1'b1;
        if (digit == 4'd9) begin
          digit <= '0;
          carry <= 1'b1;
        end else begin
          digit <= digit + 4'd1;
        end
      end else if (counting) begin
        cnt <= cnt + 27'd1;
      end
    end
  end

  // Period register: writable only while idle; zero is bumped to 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  per_reg <= PER_RST;
    else if (div_load && cur == IDLE && !clear) per_reg <= (div_val == '0) ? 27'd1 : div_val;
  end

  // Free-running display scan counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) scan_cnt <= '0;
    else       scan_cnt <= scan_cnt + 19'd1;
  end

  assign scan_sel = scan_cnt[18:17];
  assign state    = cur;

endmodule

// File: tb/tb_tick_sched.sv
// Self-checking bench for tick_sched: directed table, corner sequences,
// and randomized commands against a cycle-level behavioural model.
module tb_tick_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, pause = 1'b0, clear = 1'b0, div_load = 1'b0;
  logic [26:0] div_val = '0;
  logic        tick, carry;
  logic [3:0]  digit;
  logic [1:0]  scan_sel, state;

  int errors = 0;
  int checks = 0;

  tick_sched dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
    .div_load(div_load), .div_val(div_val), .tick(tick), .digit(digit),
    .carry(carry), .scan_sel(scan_sel), .state(state)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle / 1 run / 2 pause, elapsed cycles within
  // the current period, total ticks since clear (digit = ticks mod 10).
  int m_mode, m_el, m_per, m_ticks, m_scan;
  bit m_tick, m_carry;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_el = 0; m_per = 49_999_999; m_ticks = 0; m_scan = 0;
    m_tick = 0; m_carry = 0;
  endtask

  task automatic model_step();
    m_scan  = (m_scan + 1) % 524288;
    m_tick  = 0;
    m_carry = 0;
    if (div_load && m_mode == 0 && !clear) m_per = (div_val == 0) ? 1 : int'(div_val);
    if (clear) begin
      m_mode = 0; m_el = 0; m_ticks = 0;
    end else if (pause) begin
      if (m_mode == 1) m_mode = 2;
    end else if (start && m_mode != 1) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (m_el == m_per) begin
        m_el = 0;
        m_ticks++;
        m_tick  = 1;
        m_carry = (m_ticks % 10 == 0);
      end else begin
        m_el++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("m_state", state, m_mode);
    chk("m_tick", tick, m_tick);
    chk("m_digit", digit, m_ticks % 10);
    chk("m_carry", carry, m_carry);
    chk("m_scan", scan_sel, (m_scan >> 17) & 3);
  endtask

  task automatic drive(input bit s, input bit p, input bit c, input bit l, input int v);
    start = s; pause = p; clear = c; div_load = l; div_val = 27'(v);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit s, p, c, l;
    int v;
    int st;
    bit tk;
    int dg;
    bit cy;
  } vec_t;

  vec_t tbl[$];
  int   n;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_tick", tick, 0);
    chk("rst_digit", digit, 0);
    chk("rst_carry", carry, 0);
    chk("rst_scan", scan_sel, 0);
    do_reset();

    // Directed table: inputs held for one edge, expected outputs after it
    tbl.push_back('{0,0,0,1,3, 0,0,0,0});  // load period 4
    tbl.push_back('{1,0,0,0,0, 1,0,0,0});  // start
    tbl.push_back('{0,0,0,0,0, 1,0,0,0});
    tbl.push_back('{0,0,0,0,0, 1,0,0,0});
    tbl.push_back('{0,0,0,0,0, 1,0,0,0});
    tbl.push_back('{0,0,0,0,0, 1,1,1,0});  // first tick, 4th edge
    tbl.push_back('{0,0,0,0,0, 1,0,1,0});
    tbl.push_back('{0,0,0,0,0, 1,0,1,0});
    tbl.push_back('{0,0,0,0,0, 1,0,1,0});
    tbl.push_back('{0,0,0,0,0, 1,1,2,0});
    tbl.push_back('{0,1,1,0,0, 0,0,0,0});  // pause+clear -> idle
    tbl.push_back('{1,0,0,0,0, 1,0,0,0});
    tbl.push_back('{0,0,0,0,0, 1,0,0,0});
    tbl.push_back('{0,0,0,0,0, 1,0,0,0});
    tbl.push_back('{0,0,0,0,0, 1,0,0,0});
    tbl.push_back('{0,0,0,0,0, 1,1,1,0});  // period kept at 4
    tbl.push_back('{0,1,0,0,0, 2,0,1,0});  // pause
    tbl.push_back('{0,1,0,0,0, 2,0,1,0});  // pause in PAUSE: no effect
    tbl.push_back('{1,1,0,0,0, 2,0,1,0});  // pause masks start
    tbl.push_back('{1,0,0,0,0, 1,0,1,0});  // resume
    tbl.push_back('{0,0,0,0,0, 1,0,1,0});
    tbl.push_back('{0,0,0,0,0, 1,0,1,0});
    tbl.push_back('{0,0,0,0,0, 1,0,1,0});
    tbl.push_back('{0,0,0,0,0, 1,1,2,0});
    tbl.push_back('{0,0,1,0,0, 0,0,0,0});  // clear
    tbl.push_back('{0,1,0,0,0, 0,0,0,0});  // pause in IDLE: no effect
    tbl.push_back('{1,0,0,0,0, 1,0,0,0});
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].l, tbl[i].v);
      step();
      chk($sformatf("tbl%0d_state", i), state, tbl[i].st);
      chk($sformatf("tbl%0d_tick", i), tick, tbl[i].tk);
      chk($sformatf("tbl%0d_digit", i), digit, tbl[i].dg);
      chk($sformatf("tbl%0d_carry", i), carry, tbl[i].cy);
    end

    // 20 periods of 2 cycles: carry on ticks 10 and 20
    do_reset();
    drive(0, 0, 0, 1, 1); step();
    drive(1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tick) begin
        n++;
        chk("carry_wrap", carry, (n % 10 == 0));
        chk("digit_wrap", digit, n % 10);
      end else begin
        chk("carry_notick", carry, 0);
      end
    end
    chk("tick_count20", n, 20);

    // Pause at cnt=5 with period 8, resume: tick 3 edges after restart
    do_reset();
    drive(0, 0, 0, 1, 7); step();
    drive(1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0);
    repeat (5) step();
    drive(0, 1, 0, 0, 0); step();
    chk("pause_state", state, 2);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("paused_tick", tick, 0);
      chk("paused_state", state, 2);
    end
    drive(1, 0, 0, 0, 0); step();
    chk("resume_state", state, 1);
    drive(0, 0, 0, 0, 0);
    step(); chk("resume_t1", tick, 0);
    step(); chk("resume_t2", tick, 0);
    step(); chk("resume_t3", tick, 1);

    // div_val=0 gives period 2; a load while running is ignored
    do_reset();
    drive(0, 0, 0, 1, 0); step();
    drive(1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0);
    step(); chk("p2_a", tick, 0);
    step(); chk("p2_b", tick, 1);
    drive(0, 0, 0, 1, 9);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("p2_run", tick, i % 2);
    end
    drive(0, 0, 0, 0, 0);

    // Async reset just before a due tick
    do_reset();
    drive(0, 0, 0, 1, 3); step();
    drive(1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0);
    step(); step(); step();
    #2 reset = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_tick", tick, 0);
    chk("arst_scan", scan_sel, 0);
    @(posedge clk); #1;
    chk("arst_tick_edge", tick, 0);
    chk("arst_digit", digit, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 50; i++) begin
      step();
      chk("post_rst_idle", state, 0);
    end

    // Randomized commands against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15,
            int'($urandom_range(0, 5)));
      step();
    end
    drive(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
